axis_peak_capture: RTL and testbench
====================================

# axis_peak_capture

Parametrised multi-channel AXI-stream peak detector and burst capturer, the next generation of the team's peak detection stage. Per-channel boxcar averages of sample magnitude set a runtime-programmable threshold. The first sample exceeding it triggers capture of a configurable pre-/post-trigger window from a ring buffer. The burst is emitted as one framed AXI-stream packet, tagged with the triggering-channel mask, followed by a holdoff period.

## Interface
- NUM_CHANNELS, 4, number of antenna channels
- CHANNEL_WIDTH, 32, bits per channel in both data and magnitude buses
- PRE_TRIGGER, 8, samples before the trigger sample in each burst; 0 ≤ PRE_TRIGGER ≤ 2^AVG_POWER
- POST_TRIGGER, 24, samples from the trigger sample onward, trigger included; ≥ 1
- AVG_POWER, 4, boxcar length is 2^AVG_POWER samples
- HOLDOFF, 64, accepted samples after a burst during which triggering is blocked; ≥ PRE_TRIGGER
- Derived: BURST = PRE_TRIGGER + POST_TRIGGER; DW = NUM_CHANNELS*CHANNEL_WIDTH
- clk  in  1  sole clock
- rst_n  in  1  synchronous, active-low reset
- s_axis_tvalid  in  1  input beat valid
- s_axis_tready  out  1  input ready
- s_axis_tdata  in  DW  raw samples, channel n at bits [n*CHANNEL_WIDTH +: CHANNEL_WIDTH]
- s_axis_tdata_abs  in  DW  unsigned per-channel magnitude, same packing, same beat
- cfg_thresh_shift  in  3  threshold multiplier exponent (0..7)
- cfg_chan_mask  in  NUM_CHANNELS  1 = channel may trigger
- m_axis_tvalid  out  1  burst beat valid
- m_axis_tready  in  1  downstream ready
- m_axis_tdata  out  DW  captured raw samples
- m_axis_tuser  out  NUM_CHANNELS  triggering-channel mask; first beat only, 0 on all other beats
- m_axis_tlast  out  1  last beat of burst
- trig_count  out  16  saturating count of triggers since reset

## Operation
- Accepted beat: s_axis_tvalid & s_axis_tready. Averager, ring buffer, warm-up counter, capture counter and holdoff counter advance only on accepted beats.
- Averager per channel: running sum of the 2^AVG_POWER magnitudes strictly preceding the current beat. Sum width is CHANNEL_WIDTH+AVG_POWER. avg = sum >> AVG_POWER.
- Hit per channel: cfg_chan_mask[n] & (abs[n] > ((avg[n]+1) << cfg_thresh_shift)). Comparison is unsigned, at CHANNEL_WIDTH+AVG_POWER+8 bits, with no truncation.
- Ring buffer: depth is the next power of two ≥ BURST. It writes s_axis_tdata on every accepted beat.
- FSM:
  - WARMUP (reset state): leaves for ARMED once 2^AVG_POWER beats have been accepted.
  - ARMED: on an accepted beat with any hit, latch the hit vector into the tuser register and increment trig_count (saturating at 0xFFFF). Then go to CAPTURE, or directly to DRAIN if POST_TRIGGER == 1.
  - CAPTURE: accept POST_TRIGGER−1 further beats with no triggering, then go to DRAIN.
  - DRAIN: s_axis_tready = 0. Emit BURST beats, oldest first: samples T−PRE_TRIGGER … T+POST_TRIGGER−1. The tlast beat handshake moves the FSM to HOLDOFF.
  - HOLDOFF: accept HOLDOFF beats with no triggering, then go to ARMED. The averager keeps running.
- cfg_* inputs are used combinationally on every beat. A change takes effect on the next accepted beat.

## Timing
- Reset (rst_n low at a clk edge):
  - Outputs: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, trig_count=0, s_axis_tready=1.
  - State: all sums, counters and pointers cleared; FSM to WARMUP.
- Reset mid-burst: the burst is abandoned, no tlast is emitted, and the next cycle obeys the reset values.
- s_axis_tready is 1 in every state except DRAIN, and is registered from the FSM state.
- Trigger decision is made on the accepting edge of beat T.
- m_axis_tvalid rises the cycle after the accepting edge of beat T+POST_TRIGGER−1.
- m_axis_tvalid stays high until the tlast beat is accepted. tdata, tuser and tlast are held stable while tvalid & ~tready.
- Back-to-back beats: with m_axis_tready held high, BURST beats are emitted on BURST consecutive cycles. The RAM read is prefetched, so there are no bubbles.
- s_axis_tready returns to 1 the cycle after the tlast handshake.
- Several channels hitting on the same beat: all of them appear in tuser.
- A hit during CAPTURE, HOLDOFF or WARMUP is ignored.
- Ring pointer wraps modulo depth. The read start address is the write pointer minus BURST, modulo depth.

## Test plan
- Defaults, cfg_thresh_shift=3, mask=4'hF. Constant abs=100 for 40 beats, then ch2 abs=2000 at beat 40 → one packet of 32 beats:
  - beat 0 = input beat 32, beat 8 = beat 40, tlast on beat 31;
  - tuser=4'b0100 on beat 0 only;
  - trig_count=1.
- Same stimulus with mask=4'b1011 → no packet, trig_count=0.
- Threshold boundary: avg=100, shift=3 → abs=808 does not trigger; abs=809 triggers.
- Backpressure: m_axis_tready toggled 1/0 every cycle → data order intact, s_axis_tready low throughout DRAIN, 32 beats total.
- Second peak at 20 beats after tlast (inside HOLDOFF=64) → ignored. Peak at 70 beats after tlast → second packet, trig_count=2.
- rst_n low for 1 cycle during DRAIN beat 10 → tvalid=0 next cycle, no trigger possible for the next 16 accepted beats.

Source files
------------

// File: rtl/axis_peak_capture.sv
// axis_peak_capture
//   Multi-channel AXI-stream peak detector and burst capturer. Each channel
//   keeps a boxcar average of the sample magnitude over the previous
//   2^AVG_POWER accepted beats. The first armed beat whose magnitude exceeds
//   (avg+1) << cfg_thresh_shift on an enabled channel is the trigger. The
//   design then captures POST_TRIGGER beats from the trigger onward, and
//   replays PRE_TRIGGER+POST_TRIGGER beats from a ring buffer as one
//   AXI-stream packet. A holdoff window of HOLDOFF accepted beats follows,
//   during which triggering is blocked.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   s_axis_tvalid/tready input handshake
//   s_axis_tdata         raw samples, channel n at [n*CHANNEL_WIDTH +: CHANNEL_WIDTH]
//   s_axis_tdata_abs     unsigned per-channel magnitudes, same packing
//   cfg_thresh_shift     threshold multiplier exponent
//   cfg_chan_mask        per-channel trigger enable
//   m_axis_tvalid/tready output handshake
//   m_axis_tdata         captured raw samples, oldest first
//   m_axis_tuser         triggering-channel mask on the first beat, else 0
//   m_axis_tlast         last beat of the burst
//   trig_count           saturating trigger count since reset
module axis_peak_capture #(
  parameter int NUM_CHANNELS  = 4,
  parameter int CHANNEL_WIDTH = 32,
  parameter int PRE_TRIGGER   = 8,
  parameter int POST_TRIGGER  = 24,
  parameter int AVG_POWER     = 4,
  parameter int HOLDOFF       = 64
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    s_axis_tvalid,
  output logic                                    s_axis_tready,
  input  logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0]   s_axis_tdata,
  input  logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0]   s_axis_tdata_abs,
  input  logic [2:0]                              cfg_thresh_shift,
  input  logic [NUM_CHANNELS-1:0]                 cfg_chan_mask,
  output logic                                    m_axis_tvalid,
  input  logic                                    m_axis_tready,
  output logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0]   m_axis_tdata,
  output logic [NUM_CHANNELS-1:0]                 m_axis_tuser,
  output logic                                    m_axis_tlast,
  output logic [15:0]                             trig_count
);

  localparam int BURST  = PRE_TRIGGER + POST_TRIGGER;
  localparam int DW     = NUM_CHANNELS * CHANNEL_WIDTH;
  localparam int SW     = CHANNEL_WIDTH + AVG_POWER;
  localparam int TW     = SW + 8;
  localparam int NAVG   = 1 << AVG_POWER;
  localparam int HPW    = (AVG_POWER > 0) ? AVG_POWER : 1;
  localparam int RPW    = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int RDEPTH = 1 << RPW;
  localparam int WCW    = AVG_POWER + 1;
  localparam int CCW    = $clog2(POST_TRIGGER + 1);
  localparam int OCW    = $clog2(BURST + 1);
  localparam int HCW    = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  localparam logic [WCW-1:0] WARM_FULL = WCW'(NAVG);
  localparam logic [WCW-1:0] WARM_LAST = WCW'(NAVG - 1);
  localparam logic [HPW-1:0] HIST_LAST = HPW'(NAVG - 1);
  localparam logic [CCW-1:0] CAP_LAST  = CCW'(POST_TRIGGER - 2);
  localparam logic [OCW-1:0] OUT_LAST  = OCW'(BURST - 1);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLDOFF - 1);
  localparam logic [RPW-1:0] BURST_M1  = RPW'(BURST - 1);

  typedef enum logic [2:0] {
    S_WARMUP,
    S_ARMED,
    S_CAPTURE,
    S_DRAIN,
    S_HOLDOFF
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t                   state, state_next;
  logic [WCW-1:0]           wcnt;
  logic [HPW-1:0]           hptr;
  logic [RPW-1:0]           wptr, rptr, start_addr;
  logic [CCW-1:0]           cap_cnt;
  logic [HCW-1:0]           hold_cnt;
  logic [OCW-1:0]           out_cnt;
  logic [NUM_CHANNELS-1:0]  tuser_lat, first_tuser, hit;
  logic [SW-1:0]            sum_q [NUM_CHANNELS];
  logic [SW-1:0]            sum_d [NUM_CHANNELS];
  logic [TW-1:0]            thr   [NUM_CHANNELS];
  logic [CHANNEL_WIDTH-1:0] mag   [NUM_CHANNELS];
  logic [CHANNEL_WIDTH-1:0] hist  [NUM_CHANNELS][NAVG];
  logic [DW-1:0]            ring  [RDEPTH];
  logic                     accept, trig, warm_full, m_hs, drain_start, adv_beat;

  assign accept      = s_axis_tvalid & s_axis_tready;
  assign warm_full   = (wcnt == WARM_FULL);
  assign trig        = (state == S_ARMED) & accept & (|hit);
  assign m_hs        = m_axis_tvalid & m_axis_tready;
  assign drain_start = (state != S_DRAIN) & (state_next == S_DRAIN);
  assign adv_beat    = (state == S_DRAIN) & m_hs & ~m_axis_tlast;
  // Oldest sample of the burst; the write of the final capture beat lands on
  // the same edge, so this address is one past that beat minus BURST.
  assign start_addr  = wptr - BURST_M1;
  // With no post-trigger capture the hit vector is still live when draining starts.
  assign first_tuser = (state == S_ARMED) ? hit : tuser_lat;

  // Stage: magnitude averaging and threshold compare
  always_comb begin
    hit = '0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      mag[ch]   = s_axis_tdata_abs[ch*CHANNEL_WIDTH +: CHANNEL_WIDTH];
      thr[ch]   = (TW'(sum_q[ch] >> AVG_POWER) + TW'(1)) << cfg_thresh_shift;
      hit[ch]   = cfg_chan_mask[ch] & (TW'(mag[ch]) > thr[ch]);
      // History slots are not reset, so the oldest sample is only retired
      // once the window has been filled since the last reset.
      sum_d[ch] = sum_q[ch] + SW'(mag[ch])
                  - (warm_full ? SW'(hist[ch][hptr]) : {SW{1'b0}});
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_WARMUP:  if (accept && wcnt == WARM_LAST) state_next = S_ARMED;
      S_ARMED:   if (trig) state_next = (POST_TRIGGER == 1) ? S_DRAIN : S_CAPTURE;
      S_CAPTURE: if (accept && cap_cnt == CAP_LAST) state_next = S_DRAIN;
      S_DRAIN:   if (m_hs && m_axis_tlast) state_next = (HOLDOFF == 0) ? S_ARMED : S_HOLDOFF;
      S_HOLDOFF: if (accept && hold_cnt == HOLD_LAST) state_next = S_ARMED;
      default:   state_next = S_WARMUP;
    endcase
  end

  // Stage: control state, counters and output framing
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_WARMUP;
      s_axis_tready <= 1'b1;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= '0;
      trig_count    <= '0;
      tuser_lat     <= '0;
      wcnt          <= '0;
      hptr          <= '0;
      wptr          <= '0;
      rptr          <= '0;
      cap_cnt       <= '0;
      hold_cnt      <= '0;
      out_cnt       <= '0;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) sum_q[ch] <= '0;
    end else begin
      state         <= state_next;
      s_axis_tready <= (state_next != S_DRAIN);

      if (accept) begin
        if (!warm_full) wcnt <= wcnt + 1'b1;
        hptr <= (hptr == HIST_LAST) ? '0 : hptr + 1'b1;
        wptr <= wptr + 1'b1;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) sum_q[ch] <= sum_d[ch];
      end

      if (trig) begin
        tuser_lat  <= hit;
        trig_count <= sat_inc16(trig_count);
      end

      if (state != S_CAPTURE) cap_cnt <= '0;
      else if (accept)        cap_cnt <= cap_cnt + 1'b1;

      if (state != S_HOLDOFF) hold_cnt <= '0;
      else if (accept)        hold_cnt <= hold_cnt + 1'b1;

      if (drain_start) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tuser  <= first_tuser;
        m_axis_tlast  <= (BURST == 1);
        rptr          <= start_addr + 1'b1;
        out_cnt       <= '0;
      end else if (state == S_DRAIN && m_hs) begin
        if (m_axis_tlast) begin
          m_axis_tvalid <= 1'b0;
          m_axis_tlast  <= 1'b0;
          m_axis_tuser  <= '0;
        end else begin
          m_axis_tuser <= '0;
          m_axis_tlast <= ((out_cnt + 1'b1) == OUT_LAST);
          out_cnt      <= out_cnt + 1'b1;
          rptr         <= rptr + 1'b1;
        end
      end
    end
  end

  // Stage: sample storage and prefetched burst readout
  always_ff @(posedge clk) begin
    if (accept) begin
      ring[wptr] <= s_axis_tdata;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) hist[ch][hptr] <= mag[ch];
    end
    if (drain_start)   m_axis_tdata <= (BURST == 1) ? s_axis_tdata : ring[start_addr];
    else if (adv_beat) m_axis_tdata <= ring[rptr];
  end

endmodule

// File: tb/tb_axis_peak_capture.sv
// Self-checking bench for axis_peak_capture. A behavioural model keeps the
// full history of accepted beats since reset, computes each beat's trigger
// decision from the boxcar rule directly, and pushes every expected output
// beat into a queue; a monitor pops and compares on each output handshake.
module tb_axis_peak_capture;

  localparam int NC    = 4;
  localparam int CW    = 32;
  localparam int PRE   = 8;
  localparam int POST  = 24;
  localparam int AVG_P = 4;
  localparam int HOLD  = 64;
  localparam int BURST = PRE + POST;
  localparam int NAVG  = 1 << AVG_P;
  localparam int DW    = NC * CW;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [NC-1:0] user;
    logic          last;
  } beat_t;

  logic          clk, rst_n;
  logic          s_axis_tvalid, s_axis_tready;
  logic [DW-1:0] s_axis_tdata, s_axis_tdata_abs;
  logic [2:0]    cfg_thresh_shift;
  logic [NC-1:0] cfg_chan_mask;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [DW-1:0] m_axis_tdata;
  logic [NC-1:0] m_axis_tuser;
  logic [15:0]   trig_count;

  axis_peak_capture #(
    .NUM_CHANNELS(NC), .CHANNEL_WIDTH(CW), .PRE_TRIGGER(PRE),
    .POST_TRIGGER(POST), .AVG_POWER(AVG_P), .HOLDOFF(HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tdata_abs(s_axis_tdata_abs),
    .cfg_thresh_shift(cfg_thresh_shift), .cfg_chan_mask(cfg_chan_mask),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
    .m_axis_tlast(m_axis_tlast), .trig_count(trig_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [DW-1:0] m_abs[$];
  logic [DW-1:0] m_data[$];
  beat_t         exp_q[$];
  int            allowed_from;
  logic          pend;
  int            pend_t;
  logic [NC-1:0] pend_user;
  logic [15:0]   exp_trig;

  // Monitor state
  int     cyc = 0;
  int     pkt_beats = 0, last_pkt_beats = 0, last_pkt_cycles = 0, pkt_start = 0, pkts_done = 0;
  logic   stall_v = 1'b0;
  logic [159:0] stall_val;
  beat_t  mon_e;
  int     bp_mode = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_abs.delete();
    m_data.delete();
    exp_q.delete();
    allowed_from = NAVG;
    pend         = 1'b0;
    pend_t       = 0;
    pend_user    = '0;
    exp_trig     = '0;
  endfunction

  function automatic void model_accept(input logic [DW-1:0] d, input logic [DW-1:0] a);
    int            t;
    logic [NC-1:0] h;
    logic [63:0]   s, thr, v;
    logic [DW-1:0] old;
    beat_t         e;
    t = m_abs.size();
    h = '0;
    if (t >= allowed_from) begin
      for (int ch = 0; ch < NC; ch++) begin
        s = 64'd0;
        for (int k = 1; k <= NAVG; k++) begin
          if (t - k >= 0) begin
            old = m_abs[t-k];
            s = s + 64'(old[ch*CW +: CW]);
          end
        end
        thr = ((s / 64'(NAVG)) + 64'd1) * (64'd1 << cfg_thresh_shift);
        v   = 64'(a[ch*CW +: CW]);
        if (cfg_chan_mask[ch] && v > thr) h[ch] = 1'b1;
      end
    end
    m_abs.push_back(a);
    m_data.push_back(d);
    if (h != '0) begin
      pend         = 1'b1;
      pend_t       = t;
      pend_user    = h;
      allowed_from = t + POST + HOLD;
      if (exp_trig != 16'hFFFF) exp_trig = exp_trig + 16'd1;
    end
    if (pend && t == pend_t + POST - 1) begin
      for (int i = 0; i < BURST; i++) begin
        e.data = m_data[pend_t - PRE + i];
        e.user = (i == 0) ? pend_user : '0;
        e.last = (i == BURST - 1);
        exp_q.push_back(e);
      end
      pend = 1'b0;
    end
  endfunction

  task automatic send(input logic [DW-1:0] a);
    logic [DW-1:0] d;
    int w;
    d = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    s_axis_tvalid    = 1'b1;
    s_axis_tdata     = d;
    s_axis_tdata_abs = a;
    w = 0;
    while (!s_axis_tready && w < 1000) begin
      @(negedge clk);
      w++;
    end
    check("s_ready_wait", 160'(s_axis_tready), 160'(1'b1));
    if (!s_axis_tready) begin
      s_axis_tvalid = 1'b0;
      return;
    end
    model_accept(d, a);
    @(posedge clk);
    #1 s_axis_tvalid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    s_axis_tvalid = 1'b0;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int w;
    w = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check(name, 160'(exp_q.size() == 0 && !m_axis_tvalid), 160'(1'b1));
  endtask

  task automatic run_peak(input int ch, input int val, input int n);
    logic [DW-1:0] a;
    for (int i = 0; i < n; i++) begin
      a = {NC{32'd100}};
      if (i == 40) a[ch*CW +: CW] = 32'(val);
      send(a);
    end
  endtask

  // Downstream ready pattern, updated just after each rising edge
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = ~m_axis_tready;
        default: m_axis_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Output monitor / scoreboard
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      stall_v   = 1'b0;
      pkt_beats = 0;
    end else begin
      if (m_axis_tvalid) check("s_ready_low_while_emitting", 160'(s_axis_tready), 160'(1'b0));
      if (stall_v) begin
        check("hold_valid", 160'(m_axis_tvalid), 160'(1'b1));
        check("hold_payload", 160'({m_axis_tdata, m_axis_tuser, m_axis_tlast}), stall_val);
      end
      stall_v   = m_axis_tvalid && !m_axis_tready;
      stall_val = 160'({m_axis_tdata, m_axis_tuser, m_axis_tlast});
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 160'(1'b1), 160'(1'b0));
        end else begin
          mon_e = exp_q.pop_front();
          check("out_tdata", 160'(m_axis_tdata), 160'(mon_e.data));
          check("out_tuser", 160'(m_axis_tuser), 160'(mon_e.user));
          check("out_tlast", 160'(m_axis_tlast), 160'(mon_e.last));
        end
        if (pkt_beats == 0) pkt_start = cyc;
        pkt_beats++;
        if (m_axis_tlast) begin
          last_pkt_beats  = pkt_beats;
          last_pkt_cycles = cyc - pkt_start + 1;
          pkt_beats       = 0;
          pkts_done++;
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] a;
    int pk, w;
    rst_n            = 1'b0;
    s_axis_tvalid    = 1'b0;
    s_axis_tdata     = '0;
    s_axis_tdata_abs = '0;
    cfg_thresh_shift = 3'd3;
    cfg_chan_mask    = 4'hF;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    check("rst_m_tvalid", 160'(m_axis_tvalid), 160'(1'b0));
    check("rst_m_tlast", 160'(m_axis_tlast), 160'(1'b0));
    check("rst_m_tuser", 160'(m_axis_tuser), 160'(4'h0));
    check("rst_trig_count", 160'(trig_count), 160'(16'd0));
    check("rst_s_tready", 160'(s_axis_tready), 160'(1'b1));

    // Single peak on channel 2
    run_peak(2, 2000, 64);
    check("t1_tvalid_rise", 160'(m_axis_tvalid), 160'(1'b1));
    check("t1_s_tready_low", 160'(s_axis_tready), 160'(1'b0));
    wait_idle("t1_idle");
    check("t1_pkt_beats", 160'(last_pkt_beats), 160'(BURST));
    check("t1_pkt_cycles", 160'(last_pkt_cycles), 160'(BURST));
    check("t1_trig_count", 160'(trig_count), 160'(16'd1));
    check("t1_s_tready_back", 160'(s_axis_tready), 160'(1'b1));

    // Triggering channel masked off
    do_reset();
    cfg_chan_mask = 4'b1011;
    pk = pkts_done;
    run_peak(2, 2000, 64);
    check("t2_no_tvalid", 160'(m_axis_tvalid), 160'(1'b0));
    check("t2_trig_count", 160'(trig_count), 160'(16'd0));
    check("t2_no_packet", 160'(pkts_done), 160'(pk));
    cfg_chan_mask = 4'hF;

    // Threshold boundary: (100+1)<<3 = 808
    do_reset();
    run_peak(0, 808, 64);
    check("t3_808_trig_count", 160'(trig_count), 160'(16'd0));
    do_reset();
    run_peak(0, 809, 41);
    check("t3_809_trig_count", 160'(trig_count), 160'(16'd1));
    run_peak(0, 100, 23);
    wait_idle("t3_idle");
    check("t3_pkt_beats", 160'(last_pkt_beats), 160'(BURST));

    // Backpressure toggling every cycle
    do_reset();
    bp_mode = 1;
    run_peak(2, 2000, 64);
    check("t4_tvalid_rise", 160'(m_axis_tvalid), 160'(1'b1));
    wait_idle("t4_idle");
    check("t4_pkt_beats", 160'(last_pkt_beats), 160'(BURST));
    bp_mode = 0;

    // Holdoff: peak 20 beats after the burst is ignored, 70 beats after fires
    pk = pkts_done;
    for (int i = 0; i < 94; i++) begin
      a = {NC{32'd100}};
      if (i == 20 || i == 70) a[1*CW +: CW] = 32'd2000;
      send(a);
      if (i == 21) check("t5_holdoff_ignored", 160'(trig_count), 160'(16'd1));
    end
    wait_idle("t5_idle");
    check("t5_trig_count", 160'(trig_count), 160'(16'd2));
    check("t5_second_packet", 160'(pkts_done), 160'(pk + 1));

    // Reset in the middle of draining
    do_reset();
    run_peak(2, 2000, 64);
    w = 0;
    while (pkt_beats < 10 && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("t6_drain_progress", 160'(pkt_beats >= 10), 160'(1'b1));
    do_reset();
    check("t6_tvalid_after_rst", 160'(m_axis_tvalid), 160'(1'b0));
    check("t6_s_tready_after_rst", 160'(s_axis_tready), 160'(1'b1));
    check("t6_trig_after_rst", 160'(trig_count), 160'(16'd0));
    for (int i = 0; i < 44; i++) begin
      if (i == 16) begin
        check("t6_warmup_blocked", 160'(trig_count), 160'(16'd0));
        check("t6_warmup_no_tvalid", 160'(m_axis_tvalid), 160'(1'b0));
      end
      a = {NC{32'd100}};
      if (i == 10 || i == 20) a[3*CW +: CW] = 32'd5000;
      send(a);
    end
    wait_idle("t6_idle");
    check("t6_trig_count", 160'(trig_count), 160'(16'd1));

    // Randomised traffic with random downstream ready
    do_reset();
    bp_mode          = 2;
    cfg_thresh_shift = 3'($urandom_range(0, 3));
    cfg_chan_mask    = 4'($urandom_range(1, 15));
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        cfg_thresh_shift = 3'($urandom_range(0, 3));
        cfg_chan_mask    = 4'($urandom_range(0, 15));
      end
      for (int ch = 0; ch < NC; ch++)
        a[ch*CW +: CW] = ($urandom_range(0, 99) < 3) ? $urandom_range(500, 5000)
                                                     : $urandom_range(0, 200);
      send(a);
    end
    for (int i = 0; i < 30; i++) send('0);
    wait_idle("t7_idle");
    check("t7_trig_count", 160'(trig_count), 160'(exp_trig));
    bp_mode = 0;

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
